// File: rtl/sampler_mixer_pkg.sv
// rtl/sampler_mixer_pkg.sv - shared constants, FSM type and arithmetic helpers for the sample mixer
package sampler_mixer_pkg;

  localparam int TUSER_ID_MSB         = 5;
  localparam int TUSER_LAST_VOICE_BIT = 6;
  localparam int SAMPLE_W             = 16;
  localparam int ACC_W                = 22;

  localparam logic signed [31:0] SAT_MAX = 32'sd32767;
  localparam logic signed [31:0] SAT_MIN = -32'sd32768;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_MIX   = 1'b1
  } mixer_state_t;

  // Sign-extend one 16-bit channel sample to accumulator width
  function automatic logic signed [ACC_W-1:0] sext16(input logic [SAMPLE_W-1:0] s);
    return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  // Sign-extend an accumulator value to 32 bits for the clamp and gain arithmetic
  function automatic logic signed [31:0] widen(input logic signed [ACC_W-1:0] x);
    return {{(32-ACC_W){x[ACC_W-1]}}, x};
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat16_w(input logic signed [31:0] x);
    logic [SAMPLE_W-1:0] r;
    if (x > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (x < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

  function automatic logic clip16_w(input logic signed [31:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
    return sat16_w(widen(x));
  endfunction

  function automatic logic clip16(input logic signed [ACC_W-1:0] x);
    return clip16_w(widen(x));
  endfunction

endpackage

// File: rtl/sample_mixer_acc_ram.sv
// rtl/sample_mixer_acc_ram.sv - per-word stereo accumulator memory, async read / sync write
module sample_mixer_acc_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 44,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset: the first voice of a sequence ignores what is stored
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_dma_mixer.sv
// rtl/sample_dma_mixer.sv - voice-summing stereo mixer between DMA receiver and playback FIFO (option: SAMPLE_MIXER_GAIN_EN)
module sample_dma_mixer
  import sampler_mixer_pkg::*;
#(
  parameter int C_AXI_STREAM_TDATA_WIDTH = 32,
  parameter int C_AXI_STREAM_TUSER_WIDTH = 32,
  parameter int MAX_WORDS                = 64,
  parameter int ACC_WIDTH                = ACC_W
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                stop,
`ifdef SAMPLE_MIXER_GAIN_EN
  input  logic [7:0]                          master_gain,
`endif
  input  logic [C_AXI_STREAM_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  input  logic [C_AXI_STREAM_TUSER_WIDTH-1:0] s_axis_tuser,
  output logic                                s_axis_tready,
  output logic [C_AXI_STREAM_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [15:0]                         sat_count,
  output logic                                burst_overflow
);

  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [AW-1:0] IDX_MAX = AW'(MAX_WORDS - 1);

  mixer_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          first_voice_q, first_voice_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   sat_count_q, sat_count_d;
  logic [31:0]   m_tdata_q, m_tdata_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  // Holds s_axis_tready low while in reset and for the first cycle after it
  logic          live_q;

  logic [2*ACC_WIDTH-1:0] acc_rdata;
  logic                   acc_we;
  logic signed [ACC_WIDTH-1:0] addend_l, addend_r, sum_l, sum_r;
  logic last_voice, mix_path, out_free, beat, mix_beat;
  logic load_en, load_last, mix_clip;
  logic signed [31:0] mix_l, mix_r;
  logic unused_tuser;

  assign unused_tuser = ^{s_axis_tuser[C_AXI_STREAM_TUSER_WIDTH-1:TUSER_LAST_VOICE_BIT+1],
                          s_axis_tuser[TUSER_ID_MSB:0]};

  sample_mixer_acc_ram #(
    .DEPTH(MAX_WORDS),
    .WIDTH(2*ACC_WIDTH),
    .AW   (AW)
  ) u_acc_ram (
    .clk_i  (clk),
    .we_i   (acc_we),
    .waddr_i(idx_q),
    .wdata_i({sum_r, sum_l}),
    .raddr_i(idx_q),
    .rdata_o(acc_rdata)
  );

  // A beat of the final voice (or any beat once mixing has begun) goes to the output path
  assign last_voice    = s_axis_tuser[TUSER_LAST_VOICE_BIT];
  assign mix_path      = (state_q == ST_MIX) || last_voice;
  assign s_axis_tready = live_q && !stop && (!mix_path || out_free);
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign mix_beat      = beat && mix_path;
  assign acc_we        = beat && !mix_path;

  assign addend_l = first_voice_q ? '0 : acc_rdata[ACC_WIDTH-1:0];
  assign addend_r = first_voice_q ? '0 : acc_rdata[2*ACC_WIDTH-1:ACC_WIDTH];
  assign sum_l    = addend_l + sext16(s_axis_tdata[15:0]);
  assign sum_r    = addend_r + sext16(s_axis_tdata[31:16]);

`ifdef SAMPLE_MIXER_GAIN_EN
  logic signed [ACC_WIDTH-1:0] p1_l_q, p1_r_q;
  logic p1_last_q, p1_valid_q;
  logic out_adv;
  logic signed [31:0] gain_s;

  assign gain_s    = $signed({24'd0, master_gain});
  assign out_adv   = !m_tvalid_q || m_axis_tready;
  assign out_free  = !p1_valid_q || out_adv;
  assign load_en   = !stop && out_adv && p1_valid_q;
  assign load_last = p1_last_q;
  assign mix_l     = (widen(p1_l_q) * gain_s) >>> 7;
  assign mix_r     = (widen(p1_r_q) * gain_s) >>> 7;

  // Gain stage register: holds raw sums of accepted final-voice beats until the output frees up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_l_q     <= '0;
      p1_r_q     <= '0;
      p1_last_q  <= 1'b0;
      p1_valid_q <= 1'b0;
    end else if (stop) begin
      p1_valid_q <= 1'b0;
    end else if (mix_beat) begin
      p1_l_q     <= sum_l;
      p1_r_q     <= sum_r;
      p1_last_q  <= s_axis_tlast;
      p1_valid_q <= 1'b1;
    end else if (out_adv) begin
      p1_valid_q <= 1'b0;
    end
  end
`else
  assign out_free  = !m_tvalid_q || m_axis_tready;
  assign load_en   = mix_beat;
  assign load_last = s_axis_tlast;
  assign mix_l     = widen(sum_l);
  assign mix_r     = widen(sum_r);
`endif

  assign mix_clip = clip16_w(mix_l) || clip16_w(mix_r);

  // Sequence FSM: burst index, first-voice flag, overflow flag and accumulate/mix state
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    first_voice_d = first_voice_q;
    overflow_d    = overflow_q;
    if (stop) begin
      state_d       = ST_ACCUM;
      idx_d         = '0;
      first_voice_d = 1'b1;
    end else if (beat) begin
      if (s_axis_tlast) begin
        idx_d         = '0;
        first_voice_d = mix_path;
        state_d       = ST_ACCUM;
      end else begin
        state_d = mix_path ? ST_MIX : ST_ACCUM;
        if (idx_q == IDX_MAX) begin
          overflow_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // Output register: load a clamped mix, drop valid on handshake, flush on stop
  always_comb begin
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    sat_count_d = sat_count_q;
    if (stop) begin
      m_tvalid_d = 1'b0;
    end else if (load_en) begin
      m_tdata_d  = {sat16_w(mix_r), sat16_w(mix_l)};
      m_tvalid_d = 1'b1;
      m_tlast_d  = load_last;
      if (mix_clip && (sat_count_q != 16'hFFFF)) begin
        sat_count_d = sat_count_q + 16'd1;
      end
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ACCUM;
      idx_q         <= '0;
      first_voice_q <= 1'b1;
      overflow_q    <= 1'b0;
      sat_count_q   <= '0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      first_voice_q <= first_voice_d;
      overflow_q    <= overflow_d;
      sat_count_q   <= sat_count_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      live_q        <= 1'b1;
    end
  end

  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign sat_count      = sat_count_q;
  assign burst_overflow = overflow_q;

endmodule
